// File: rtl/sync_payload_capture.sv
// Payload deserialiser that follows a serial sync-word detector: on each match pulse it
// captures the next PAYLOAD_W bits MSB first and offers them on a single-entry valid/ready register.
module sync_payload_capture #(
  parameter int PAYLOAD_W = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in,
  input  logic                 sync_det,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_count,
  output logic                 overflow
);

  localparam int CW = (PAYLOAD_W > 2) ? $clog2(PAYLOAD_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(PAYLOAD_W - 1);

  // Output handshake: data_out is accepted on any rising edge where
  // data_valid && data_ready; data_valid never depends on data_ready combinationally.
  typedef enum logic {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_W-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic [CNT_W-1:0]       frame_count_q, frame_count_d;
  logic                   overflow_q, overflow_d;
  logic                   complete;
  logic [PAYLOAD_W-1:0]   word;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;
    complete      = 1'b0;
    word          = {shift_q[PAYLOAD_W-2:0], in};

    unique case (state_q)
      HUNT: begin
        if (sync_det) begin
          shift_d   = {{(PAYLOAD_W-1){1'b0}}, in};
          bit_cnt_d = CW'(1);
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        // sync_det is deliberately ignored here, including on the completion edge.
        shift_d = word;
        if (bit_cnt_q == LAST_BIT) begin
          complete  = 1'b1;
          bit_cnt_d = '0;
          state_d   = HUNT;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      default: state_d = HUNT;
    endcase

    if (complete) begin
      if (!data_valid_q || data_ready) begin
        data_out_d    = word;
        data_valid_d  = 1'b1;
        frame_count_d = frame_count_q + CNT_W'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign busy        = (state_q == CAPTURE);
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sync_payload_capture.sv
// Directed bench for sync_payload_capture with PAYLOAD_W=16: framing, backpressure,
// overflow, ignored syncs, asynchronous reset and frame counter wrap.
module tb_sync_payload_capture;

  localparam int PW = 16;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          in;
  logic          sync_det;
  logic [PW-1:0] data_out;
  logic          data_valid;
  logic          data_ready;
  logic          busy;
  logic [CW-1:0] frame_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  sync_payload_capture #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .sync_det   (sync_det),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_count(frame_count),
    .overflow   (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; pulses reset between edges.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // Drives nbits payload bits MSB first, sync_det on the first; extra_sync[k] also
  // pulses sync_det on payload bit k. ready_last >= 0 sets data_ready for the last bit.
  task automatic send_frame(input logic [PW-1:0] w, input int nbits,
                            input logic [PW-1:0] extra_sync, input int ready_last);
    for (int j = 0; j < nbits; j++) begin
      in       = w[PW-1-j];
      sync_det = (j == 0) || extra_sync[j];
      if (j == PW-1 && ready_last >= 0) data_ready = ready_last[0];
      step();
      if (j == 0) check("busy_after_e0", busy, 1);
    end
    sync_det = 1'b0;
    in       = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    in         = 1'b0;
    sync_det   = 1'b0;
    data_ready = 1'b0;
    #3;
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", frame_count, 0);
    check("rst_overflow", overflow, 0);
    #4 rst_n = 1'b1;
    step();

    // single frame with ready high; valid lasts exactly one cycle
    data_ready = 1'b1;
    send_frame(16'hA5C3, PW - 1, 16'h0, -1);
    check("t1_valid_before_done", data_valid, 0);
    send_frame(16'h0000, 0, 16'h0, -1);
    in = 1'b1;
    step();
    in = 1'b0;
    check("t1_data_out", data_out, 16'hA5C3);
    check("t1_valid", data_valid, 1);
    check("t1_busy", busy, 0);
    check("t1_count", frame_count, 1);
    check("t1_overflow", overflow, 0);
    step();
    check("t1_valid_one_cycle", data_valid, 0);
    check("t1_data_hold", data_out, 16'hA5C3);

    // backpressure hold
    data_ready = 1'b0;
    send_frame(16'h1234, PW, 16'h0, -1);
    for (int c = 0; c < 10; c++) begin
      check("t2_hold_valid", data_valid, 1);
      check("t2_hold_data", data_out, 16'h1234);
      step();
    end
    data_ready = 1'b1;
    step();
    check("t2_valid_cleared", data_valid, 0);
    check("t2_data_retained", data_out, 16'h1234);
    check("t2_count", frame_count, 2);

    // overflow: second frame dropped
    pulse_reset();
    data_ready = 1'b0;
    send_frame(16'h1111, PW, 16'h0, -1);
    send_frame(16'h2222, PW, 16'h0, -1);
    check("t3_data_out", data_out, 16'h1111);
    check("t3_valid", data_valid, 1);
    check("t3_overflow", overflow, 1);
    check("t3_count", frame_count, 1);
    step();
    check("t3_overflow_sticky", overflow, 1);

    // ready on exactly the second completion edge: replace without overflow
    pulse_reset();
    data_ready = 1'b0;
    send_frame(16'h1111, PW, 16'h0, -1);
    send_frame(16'h2222, PW, 16'h0, 1);
    data_ready = 1'b0;
    check("t4_data_out", data_out, 16'h2222);
    check("t4_valid", data_valid, 1);
    check("t4_count", frame_count, 2);
    check("t4_overflow", overflow, 0);

    // sync pulses on payload bit 5 and the completion edge are ignored
    pulse_reset();
    data_ready = 1'b1;
    send_frame(16'h5A5A, PW, 16'h8020, -1);
    check("t5_data_out", data_out, 16'h5A5A);
    check("t5_count", frame_count, 1);
    check("t5_busy_done", busy, 0);
    for (int c = 0; c < 20; c++) step();
    check("t5_count_after", frame_count, 1);
    check("t5_busy_after", busy, 0);
    check("t5_valid_after", data_valid, 0);

    // asynchronous reset after 7 payload bits
    send_frame(16'hFFFF, 7, 16'h0, -1);
    check("t6_busy_partial", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_data_out", data_out, 0);
    check("t6_rst_valid", data_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", frame_count, 0);
    check("t6_rst_overflow", overflow, 0);
    #1 rst_n = 1'b1;
    step();
    check("t6_idle_after_rst", busy, 0);
    send_frame(16'hBEEF, PW, 16'h0, -1);
    check("t6_data_out", data_out, 16'hBEEF);
    check("t6_count", frame_count, 1);
    check("t6_valid", data_valid, 1);

    // frame counter wrap
    pulse_reset();
    data_ready = 1'b1;
    for (int f = 1; f <= 256; f++) begin
      send_frame(PW'(f * 16'h0101 + 16'h0003), PW, 16'h0, -1);
      if (f == 255) check("t7_count_255", frame_count, 255);
    end
    check("t7_count_wrap", frame_count, 0);
    check("t7_last_data", data_out, 16'h0103);
    check("t7_overflow", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
